usb_stream_fifo: RTL and testbench
==================================

Name: usb_stream_fifo

Overview:
- Byte-stream FIFO with valid/ready handshakes on both sides.
- Sits between the MUACM USB CDC core and the CPU system's ACIA byte interface, in both directions:
  - one instance on RX: MUACM out -> CPU rx_data/rx_val/rx_rdy.
  - one instance on TX: CPU tx_data/tx_val/tx_rdy -> MUACM in.
- Absorbs USB packet bursts so the 6502 can poll the ACIA slowly without back-pressuring the USB core every byte.
- Provides a fill level and a synchronous flush for firmware/debug.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH_LOG2, 4, log2 of entry count (default 16 entries).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  synchronous clear of contents, active-high.
- in_data  in  WIDTH  write-side data.
- in_val  in  1  write-side valid.
- in_rdy  out  1  write-side ready.
- out_data  out  WIDTH  read-side data (first-word fall-through).
- out_val  out  1  read-side valid.
- out_rdy  in  1  read-side ready.
- level  out  DEPTH_LOG2+1  current entry count, 0..2^DEPTH_LOG2.
- full  out  1  level == 2^DEPTH_LOG2.
- empty  out  1  level == 0.

Behaviour:
- Reset: clk single clock; rst_n synchronous, active-low. While rst_n=0 at a rising edge:
  - pointers and count clear.
  - Outputs: level=0, empty=1, full=0, out_val=0, out_data=0.
  - in_rdy=0 while rst_n is low; in_rdy=1 on the first cycle after release.
  - Reset mid-transfer discards all contents; no partial state survives.
- Storage: 2^DEPTH_LOG2 x WIDTH register array. Write pointer and read pointer are DEPTH_LOG2 bits wide and wrap modulo depth. A separate count register of DEPTH_LOG2+1 bits drives level, full and empty.
- Push: occurs when in_val & in_rdy at a rising edge. mem[wr_ptr] <= in_data, then wr_ptr++.
- Pop: occurs when out_val & out_rdy at a rising edge. rd_ptr++.
- Output path:
  - in_rdy = !full & rst_n. It is derived from registered state only; there is no combinational path from out_rdy to in_rdy.
  - out_val = !empty.
  - out_data = mem[rd_ptr], with no extra register stage.
- Latency: a byte pushed at edge N is visible on out_data/out_val after edge N (usable at edge N+1). Empty-to-valid latency is 1 cycle.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Full boundary: in_rdy=0, so no push. A pop while full leaves level=DEPTH-1, and in_rdy returns to 1 the next cycle.
- Empty boundary: out_val=0, so no pop. A push while empty makes out_val=1 the next cycle.
- Ordering: strict FIFO order. Wrap-around is transparent; nothing is lost or duplicated across the pointer wrap.
- Stability: while out_val=1 and out_rdy=0, out_data holds constant. Pushes never alter the head entry.
- Flush (rst_n=1, flush=1):
  - Pointers and count clear at that edge.
  - Flush has priority over any push or pop in the same cycle; that push is dropped and that pop is not counted.
  - in_rdy stays 1 during flush unless the FIFO is full.
- Upstream obligation: the producer holds in_data stable while in_val=1 and in_rdy=0. The FIFO does not check this.
- Combinational paths: none from in_val to out_val, and none from out_rdy to in_rdy. All outputs except out_data are functions of registers only.

Test Plan:
- Reset release: hold rst_n=0 for 3 cycles with in_val=1 -> in_rdy=0, level=0, empty=1, out_val=0. First cycle after release -> in_rdy=1.
- Single byte: push 0xA5 at edge N with out_rdy=0 -> out_val=1 and out_data=0xA5 after edge N, level=1. Pulse out_rdy -> empty=1, level=0.
- Fill to full: push 0x00..0x0F (DEPTH_LOG2=4) -> full=1, level=16, in_rdy=0. A 17th byte 0xFF held on in_val is not accepted. One pop returns 0x00, then 0xFF is accepted the following cycle and level returns to 16.
- Wrap/streaming: continuous in_val=1 and out_rdy=1 with an incrementing pattern over 100 bytes, starting from level=3 -> level stays 3 throughout. Output sequence is contiguous with no gaps or duplicates across pointer wraps.
- Back-pressure: random in_val/out_rdy stalls for 1000 bytes, compared against a scoreboard -> exact order is preserved. out_data is stable whenever out_val=1 and out_rdy=0.
- Flush priority: level=5 and flush=1 with simultaneous push of 0x77 and out_rdy=1 -> next cycle level=0, empty=1, 0x77 is absent. A subsequent push of 0x12 appears as the next output.

Source files
------------

// File: rtl/usb_stream_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_stream_fifo_if : valid/ready byte-stream bundle with fill and flush. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface usb_stream_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic                  flush;
  logic [WIDTH-1:0]      in_data;
  logic                  in_val;
  logic                  in_rdy;
  logic [WIDTH-1:0]      out_data;
  logic                  out_val;
  logic                  out_rdy;
  logic [DEPTH_LOG2:0]   level;
  logic                  full;
  logic                  empty;

  // master is the side that feeds/drains the FIFO; slave is the FIFO itself
  modport master (
    output flush, in_data, in_val, out_rdy,
    input  in_rdy, out_data, out_val, level, full, empty
  );

  modport slave (
    input  flush, in_data, in_val, out_rdy,
    output in_rdy, out_data, out_val, level, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/usb_stream_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_stream_fifo : first-word fall-through byte FIFO, USB CDC <-> ACIA.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module usb_stream_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  usb_stream_fifo_if.slave   bus
);

  localparam int                  c_depth      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_full_count = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [c_depth];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_in_rdy;
  logic w_out_val;
  logic w_push;
  logic w_pop;

  // Status comes from the count register only, so out_rdy never reaches in_rdy.
  assign w_full    = (r_count == c_full_count);
  assign w_empty   = (r_count == '0);
  assign w_in_rdy  = ~w_full & rst_n;
  assign w_out_val = ~w_empty;
  assign w_push    = bus.in_val & w_in_rdy;
  assign w_pop     = w_out_val & bus.out_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < c_depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.flush) begin
      // Flush wins over any same-cycle push or pop.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.in_data;
        r_wr_ptr        <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_rdy   = w_in_rdy;
  assign bus.out_val  = w_out_val;
  assign bus.out_data = r_mem[r_rd_ptr];
  assign bus.level    = r_count;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_usb_stream_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_usb_stream_fifo : directed and scoreboarded checks of usb_stream_fifo.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_usb_stream_fifo;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  usb_stream_fifo_if #(.WIDTH(8), .DEPTH_LOG2(4)) bus ();

  usb_stream_fifo #(.WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush   = 1'b0;
    bus.in_val  = 1'b0;
    bus.in_data = 8'h00;
    bus.out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    idle_inputs();
    bus.in_val  = 1'b1;
    bus.in_data = 8'h33;
    repeat (3) step();
    n_cmp++; if (bus.in_rdy !== 1'b0) begin n_err++; $display("FAIL reset_in_rdy: got %b want 0", bus.in_rdy); end
    n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_cmp++; if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL reset_out_val: got %b want 0", bus.out_val); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
    rst_n      = 1'b1;
    bus.in_val = 1'b0;
    #1;
    n_cmp++; if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL release_in_rdy: got %b want 1", bus.in_rdy); end
    step();
    n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL release_level: got %0d want 0", bus.level); end
  endtask

  task automatic test_single();
    bus.in_data = 8'hA5;
    bus.in_val  = 1'b1;
    bus.out_rdy = 1'b0;
    step();
    bus.in_val = 1'b0;
    n_cmp++; if (bus.out_val !== 1'b1) begin n_err++; $display("FAIL single_out_val: got %b want 1", bus.out_val); end
    n_cmp++; if (bus.out_data !== 8'hA5) begin n_err++; $display("FAIL single_out_data: got %h want a5", bus.out_data); end
    n_cmp++; if (bus.level !== 5'd1) begin n_err++; $display("FAIL single_level: got %0d want 1", bus.level); end
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL single_pop_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL single_pop_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL single_pop_out_val: got %b want 0", bus.out_val); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) begin
      bus.in_data = vals[i];
      bus.in_val  = 1'b1;
      step();
    end
    n_cmp++; if (bus.level !== 5'd3) begin n_err++; $display("FAIL mid_pre_level: got %0d want 3", bus.level); end
    rst_n       = 1'b0;
    bus.in_data = 8'h44;
    step();
    n_cmp++; if (bus.in_rdy !== 1'b0) begin n_err++; $display("FAIL mid_rst_in_rdy: got %b want 0", bus.in_rdy); end
    n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL mid_rst_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_out_data: got %h want 00", bus.out_data); end
    rst_n      = 1'b1;
    bus.in_val = 1'b0;
    step();
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL mid_rel_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL mid_rel_out_val: got %b want 0", bus.out_val); end
  endtask

  task automatic test_fill();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      bus.in_data = 8'(i);
      bus.in_val  = 1'b1;
      step();
    end
    bus.in_data = 8'hFF;
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", bus.full); end
    n_cmp++; if (bus.level !== 5'd16) begin n_err++; $display("FAIL fill_level: got %0d want 16", bus.level); end
    n_cmp++; if (bus.in_rdy !== 1'b0) begin n_err++; $display("FAIL fill_in_rdy: got %b want 0", bus.in_rdy); end
    step();
    n_cmp++; if (bus.level !== 5'd16) begin n_err++; $display("FAIL fill_overflow_level: got %0d want 16", bus.level); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL fill_head: got %h want 00", bus.out_data); end
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;
    n_cmp++; if (bus.level !== 5'd15) begin n_err++; $display("FAIL fill_pop_level: got %0d want 15", bus.level); end
    n_cmp++; if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL fill_pop_in_rdy: got %b want 1", bus.in_rdy); end
    n_cmp++; if (bus.out_data !== 8'h01) begin n_err++; $display("FAIL fill_pop_head: got %h want 01", bus.out_data); end
    step();
    bus.in_val = 1'b0;
    n_cmp++; if (bus.level !== 5'd16) begin n_err++; $display("FAIL fill_refill_level: got %0d want 16", bus.level); end
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL fill_refill_full: got %b want 1", bus.full); end
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'(i + 1) : 8'hFF;
      n_cmp++; if (bus.out_data !== exp) begin n_err++; $display("FAIL fill_drain[%0d]: got %h want %h", i, bus.out_data, exp); end
      step();
    end
    bus.out_rdy = 1'b0;
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL fill_drain_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'(i);
      bus.in_val  = 1'b1;
      step();
    end
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.in_data = 8'(i + 3);
      n_cmp++; if (bus.level !== 5'd3) begin n_err++; $display("FAIL stream_level[%0d]: got %0d want 3", i, bus.level); end
      n_cmp++; if (bus.out_data !== 8'(i)) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", i, bus.out_data, 8'(i)); end
      step();
    end
    bus.in_val = 1'b0;
    for (int i = 100; i < 103; i++) begin
      n_cmp++; if (bus.out_data !== 8'(i)) begin n_err++; $display("FAIL stream_tail[%0d]: got %h want %h", i, bus.out_data, 8'(i)); end
      step();
    end
    bus.out_rdy = 1'b0;
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL stream_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_back_pressure();
    logic [7:0] q[$];
    logic [7:0] pend;
    logic       push;
    logic       pop;
    int         sent = 0;
    int         got  = 0;
    int         cyc  = 0;
    pend = 8'($urandom_range(0, 255));
    // Slow drain for the first half drives the FIFO into full; fast drain afterwards.
    while (got < 1000 && cyc < 20000) begin
      bus.in_val  = (sent < 1000) && ($urandom_range(0, 99) < 60);
      bus.in_data = pend;
      bus.out_rdy = ($urandom_range(0, 99) < ((got < 500) ? 30 : 75));
      #1;
      n_cmp++; if (bus.level !== 5'(q.size())) begin n_err++; $display("FAIL bp_level@%0d: got %0d want %0d", cyc, bus.level, q.size()); end
      n_cmp++; if (bus.in_rdy !== (q.size() < 16)) begin n_err++; $display("FAIL bp_in_rdy@%0d: got %b want %b", cyc, bus.in_rdy, q.size() < 16); end
      n_cmp++; if (bus.out_val !== (q.size() != 0)) begin n_err++; $display("FAIL bp_out_val@%0d: got %b want %b", cyc, bus.out_val, q.size() != 0); end
      if (q.size() != 0) begin
        n_cmp++; if (bus.out_data !== q[0]) begin n_err++; $display("FAIL bp_data@%0d: got %h want %h", cyc, bus.out_data, q[0]); end
      end
      push = bus.in_val && (q.size() < 16);
      pop  = bus.out_rdy && (q.size() != 0);
      step();
      cyc++;
      if (pop) begin
        void'(q.pop_front());
        got++;
      end
      if (push) begin
        q.push_back(pend);
        sent++;
        pend = 8'($urandom_range(0, 255));
      end
    end
    n_cmp++; if (got != 1000) begin n_err++; $display("FAIL bp_timeout: got %0d bytes want 1000", got); end
    idle_inputs();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'(8'h50 + i);
      bus.in_val  = 1'b1;
      step();
    end
    n_cmp++; if (bus.level !== 5'd5) begin n_err++; $display("FAIL flush_pre_level: got %0d want 5", bus.level); end
    bus.in_data = 8'h77;
    bus.out_rdy = 1'b1;
    bus.flush   = 1'b1;
    #1;
    n_cmp++; if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL flush_in_rdy: got %b want 1", bus.in_rdy); end
    step();
    bus.flush   = 1'b0;
    bus.in_val  = 1'b0;
    bus.out_rdy = 1'b0;
    n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL flush_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL flush_empty: got %b want 1", bus.empty); end
    n_cmp++; if (bus.out_val !== 1'b0) begin n_err++; $display("FAIL flush_out_val: got %b want 0", bus.out_val); end
    bus.in_data = 8'h12;
    bus.in_val  = 1'b1;
    step();
    bus.in_val = 1'b0;
    n_cmp++; if (bus.out_data !== 8'h12) begin n_err++; $display("FAIL flush_next_data: got %h want 12", bus.out_data); end
    n_cmp++; if (bus.level !== 5'd1) begin n_err++; $display("FAIL flush_next_level: got %0d want 1", bus.level); end
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL flush_final_empty: got %b want 1", bus.empty); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_reset_mid();
    test_fill();
    test_stream();
    test_back_pressure();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
